mux_arb_nx1: RTL and testbench
==============================

# mux_arb_nx1

Parametrised N-channel, W-bit registered multiplexer for the processor datapath. It selects one of CHANNELS valid/ready input streams, either by an explicit select or by round-robin arbitration, and presents the selected word through a single output register with valid/ready flow control. It is the buffered, multi-channel successor to the gate-level 2:1 mux. It sits between operand/result sources and their consumers (register-file write-back, ALU operand ports).

## Interface
Parameters:
- WIDTH, 8, data bits per channel (>= 1)
- CHANNELS, 4, number of input channels (>= 2)
- MODE, 0, 0 = explicit select via `sel`; 1 = round-robin arbitration, `sel` ignored
- SELW, derived = max(1, clog2(CHANNELS)), width of channel indices (localparam)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  input  1  rising-edge clock
  - rst  input  1  synchronous, active-high reset
- Input channels:
  - in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
  - in_valid  input  CHANNELS  per-channel word valid
  - in_ready  output  CHANNELS  per-channel accept; at most one bit high
- Select:
  - sel  input  SELW  channel select (MODE 0 only)
- Output:
  - out_data  output  WIDTH  registered selected word
  - out_chan  output  SELW  index of the channel that supplied out_data
  - out_valid  output  1  output register holds a word
  - out_ready  input  1  consumer accepts the word

## Operation
- can_accept = !out_valid | out_ready.
- Grant g is combinational:
  - MODE 0: g = sel when sel < CHANNELS. When sel >= CHANNELS there is no grant.
  - MODE 1: g = the first i with in_valid[i] set, searching ptr+1, ptr+2, … modulo CHANNELS and ending with ptr. When no input is valid there is no grant.
- in_ready[i] = can_accept & grant exists & (i == g). All other bits are 0.
  - MODE 0: in_ready[sel] does not depend on in_valid[sel].
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. On that edge:
  - out_data <= channel g word
  - out_chan <= g
  - out_valid <= 1
  - MODE 1 only: ptr <= g
- If out_valid & out_ready and no transfer occurs, out_valid <= 0. out_data and out_chan hold their values.
- Simultaneous drain and transfer on the same edge: the new word replaces the old one and out_valid stays 1. No bubble is inserted.
- While out_valid & !out_ready:
  - out_data and out_chan are stable.
  - All in_ready bits are 0.
- Round-robin fairness: a channel that stays continuously valid is granted within CHANNELS transfers.
- ptr changes only on a transfer, so an idle cycle never moves priority.
- Reset clears all state regardless of in-flight words. The word held in the output register is discarded.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_chan = 0, ptr = CHANNELS-1 (channel 0 has first priority).
  - During rst, in_ready = 0.
- Latency is 1 cycle: a word accepted at edge k is visible on out_data with out_valid=1 after edge k.
- Throughput is 1 word per cycle while out_ready = 1.
- There is no combinational path from in_data or in_valid to out_data, out_valid or out_chan.
- Combinational paths exist from out_ready to in_ready, and from sel or in_valid to in_ready.
- The first transfer can occur on the first edge after rst deasserts.

## Test plan
- Reset: assert rst for 2 cycles with all inputs valid and out_ready=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0 throughout. Release rst -> MODE 1 grants channel 0 first.
- MODE 0 streaming, W=8, N=4: hold sel=2, drive channel 2 with 0x11, 0x22, 0x33 on consecutive cycles, out_ready=1 -> out_data shows 0x11, 0x22, 0x33 on the next three cycles with out_chan=2. in_ready=4'b0100 every cycle.
- MODE 0 invalid select, N=3: set sel=3 with all inputs valid -> in_ready=0, no transfer, out_valid falls to 0 after the current word drains.
- MODE 1 fairness: all 4 channels continuously valid, out_ready=1 -> out_chan sequence 0,1,2,3,0,1,… Then drop channel 1 -> sequence skips 1: 2,3,0,2,…
- Backpressure: load 0xA5, hold out_ready=0 for 5 cycles while changing inputs -> out_data=0xA5 and out_chan stable, in_ready=0. Raise out_ready with channel 3 valid (0x5A) -> 0x5A appears next cycle with out_valid staying 1.
- Reset mid-operation: with out_valid=1 and out_ready=0, assert rst for 1 cycle -> out_valid=0 and ptr reset. In MODE 1 the next grant goes to the lowest valid channel.

Source files
------------

// File: rtl/mux_arb_nx1_if.sv
// Valid/ready bundle for the N:1 registered multiplexer.
// slave  = the multiplexer itself, master = the side driving sources and sink.
interface mux_arb_nx1_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SELW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SELW-1:0]           sel;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_arb_nx1.sv
// N-channel, W-bit registered multiplexer with explicit-select or
// round-robin grant and a single valid/ready output register.
module mux_arb_nx1 #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0
) (
  input  logic           clk,
  input  logic           rst,
  mux_arb_nx1_if.slave   bus
);
  localparam int SELW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  // Channel count at select width + 1 so sel >= CHANNELS is representable.
  localparam logic [SELW:0]   NCH_L   = (SELW+1)'(CHANNELS);
  // Pointer sits on the last channel so channel 0 is searched first.
  localparam logic [SELW-1:0] PTR_RST = SELW'(CHANNELS - 1);

  logic [WIDTH-1:0]    data_q,  data_d;
  logic [SELW-1:0]     chan_q,  chan_d;
  logic                vld_q,   vld_d;
  logic [SELW-1:0]     ptr_q,   ptr_d;

  logic                can_accept;
  logic                rr_vld;
  logic [SELW-1:0]     rr_g;
  logic                gnt_vld;
  logic [SELW-1:0]     gnt;
  logic [CHANNELS-1:0] rdy;
  logic                xfer;
  logic [WIDTH-1:0]    word;

  assign can_accept = !vld_q | bus.out_ready;

  // Round-robin search from ptr+1 around to ptr; the nearest valid wins,
  // so iterate from the farthest offset and let closer hits overwrite.
  always_comb begin
    automatic int idx;
    rr_vld = 1'b0;
    rr_g   = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % CHANNELS;
      if (bus.in_valid[idx]) begin
        rr_vld = 1'b1;
        rr_g   = SELW'(idx);
      end
    end
  end

  // Grant source: explicit select (no grant when out of range) or arbiter.
  always_comb begin
    if (MODE == 0) begin
      gnt_vld = ({1'b0, bus.sel} < NCH_L);
      gnt     = bus.sel;
    end else begin
      gnt_vld = rr_vld;
      gnt     = rr_g;
    end
  end

  // Per-channel ready: one-hot on the grant, killed by backpressure and reset.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    localparam logic [SELW-1:0] IDX = SELW'(i);
    assign rdy[i] = !rst & can_accept & gnt_vld & (gnt == IDX);
  end

  assign bus.in_ready = rdy;
  assign xfer         = |(rdy & bus.in_valid);

  // AND-OR word select driven by the one-hot ready; avoids any
  // out-of-range part-select when sel points past the last channel.
  always_comb begin
    word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      word = word | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{rdy[i]}});
    end
  end

  // Next state: load on transfer (drain+load keeps valid high), else drain.
  always_comb begin
    data_d = data_q;
    chan_d = chan_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    if (xfer) begin
      data_d = word;
      chan_d = gnt;
      vld_d  = 1'b1;
      if (MODE != 0) ptr_d = gnt;
    end else if (bus.out_ready) begin
      vld_d  = 1'b0;
    end
  end

  // Output register and arbitration pointer; reset drops any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      chan_q <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= PTR_RST;
    end else begin
      data_q <= data_d;
      chan_q <= chan_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed bench: MODE 0 (N=4), MODE 0 (N=3, bad select), MODE 1 (N=4).
module tb_mux_arb_nx1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  mux_arb_nx1_if #(.WIDTH(8), .CHANNELS(4)) b0 ();
  mux_arb_nx1_if #(.WIDTH(8), .CHANNELS(3)) b3 ();
  mux_arb_nx1_if #(.WIDTH(8), .CHANNELS(4)) b1 ();

  mux_arb_nx1 #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_sel4 (.clk(clk), .rst(rst), .bus(b0));
  mux_arb_nx1 #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u_sel3 (.clk(clk), .rst(rst), .bus(b3));
  mux_arb_nx1 #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_rr4  (.clk(clk), .rst(rst), .bus(b1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rr_a[6] = '{0, 1, 2, 3, 0, 1};
  int rr_b[4] = '{2, 3, 0, 2};
  logic [7:0] stream[3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    // reset with everything valid and the sink ready
    b0.in_data = 32'h4433_2211; b0.in_valid = 4'hf; b0.sel = 2'd0; b0.out_ready = 1'b1;
    b3.in_data = 24'h33_2211;   b3.in_valid = 3'h7; b3.sel = 2'd0; b3.out_ready = 1'b1;
    b1.in_data = 32'h1312_1110; b1.in_valid = 4'hf; b1.sel = 2'd0; b1.out_ready = 1'b1;
    #1;
    chk("rst_rdy_sel4", 32'(b0.in_ready), 32'h0);
    chk("rst_rdy_sel3", 32'(b3.in_ready), 32'h0);
    chk("rst_rdy_rr",   32'(b1.in_ready), 32'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_vld",  32'(b1.out_valid), 32'h0);
      chk("rst_data", 32'(b1.out_data),  32'h0);
      chk("rst_chan", 32'(b1.out_chan),  32'h0);
      chk("rst_rdy",  32'(b0.in_ready),  32'h0);
      chk("rst_vld0", 32'(b0.out_valid), 32'h0);
    end
    rst = 1'b0;
    b0.in_valid = 4'h0;
    b3.in_valid = 3'h0;
    #1;

    // round-robin fairness, all channels valid; channel 0 first
    for (int n = 0; n < 6; n++) begin
      chk("rr_rdy", 32'(b1.in_ready), 32'(1) << rr_a[n]);
      tick();
      chk("rr_chan", 32'(b1.out_chan),  32'(rr_a[n]));
      chk("rr_data", 32'(b1.out_data),  32'h10 + 32'(rr_a[n]));
      chk("rr_vld",  32'(b1.out_valid), 32'h1);
    end
    b1.in_valid = 4'b1101;
    #1;
    for (int n = 0; n < 4; n++) begin
      chk("rr_skip_rdy", 32'(b1.in_ready), 32'(1) << rr_b[n]);
      tick();
      chk("rr_skip_chan", 32'(b1.out_chan), 32'(rr_b[n]));
      chk("rr_skip_data", 32'(b1.out_data), 32'h10 + 32'(rr_b[n]));
    end
    // park the arbiter holding chan 2 for the mid-operation reset later
    b1.out_ready = 1'b0;
    #1;
    chk("rr_hold_rdy", 32'(b1.in_ready), 32'h0);

    // explicit select streaming on channel 2
    b0.sel = 2'd2;
    b0.in_valid = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      b0.in_data[16 +: 8] = stream[n];
      #1;
      chk("str_rdy", 32'(b0.in_ready), 32'h4);
      tick();
      chk("str_data", 32'(b0.out_data),  32'(stream[n]));
      chk("str_chan", 32'(b0.out_chan),  32'h2);
      chk("str_vld",  32'(b0.out_valid), 32'h1);
    end

    // backpressure: load A5 then stall for 5 cycles while inputs churn
    b0.in_data[16 +: 8] = 8'hA5;
    tick();
    chk("bp_load", 32'(b0.out_data), 32'hA5);
    b0.out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      b0.sel = 2'(n);
      b0.in_valid = 4'(4'hf >> (n % 3));
      b0.in_data = 32'h9000_0000 + 32'(n * 32'h0101_0101);
      #1;
      chk("bp_rdy", 32'(b0.in_ready), 32'h0);
      tick();
      chk("bp_data", 32'(b0.out_data),  32'hA5);
      chk("bp_chan", 32'(b0.out_chan),  32'h2);
      chk("bp_vld",  32'(b0.out_valid), 32'h1);
    end
    b0.out_ready = 1'b1;
    b0.sel = 2'd3;
    b0.in_valid = 4'b1000;
    b0.in_data[24 +: 8] = 8'h5A;
    #1;
    chk("bp_rel_rdy", 32'(b0.in_ready), 32'h8);
    tick();
    chk("bp_rel_data", 32'(b0.out_data),  32'h5A);
    chk("bp_rel_chan", 32'(b0.out_chan),  32'h3);
    chk("bp_rel_vld",  32'(b0.out_valid), 32'h1);
    b0.in_valid = 4'h0;
    tick();
    chk("drain_vld",  32'(b0.out_valid), 32'h0);
    chk("drain_data", 32'(b0.out_data),  32'h5A);

    // N=3 with sel=3: no grant, held word drains out
    b3.sel = 2'd1;
    b3.in_valid = 3'b010;
    b3.in_data = 24'h00_3C00;
    tick();
    chk("bad_load", 32'(b3.out_data), 32'h3C);
    b3.sel = 2'd3;
    b3.in_valid = 3'h7;
    b3.out_ready = 1'b0;
    #1;
    chk("bad_rdy_stall", 32'(b3.in_ready), 32'h0);
    tick();
    chk("bad_hold_vld", 32'(b3.out_valid), 32'h1);
    b3.out_ready = 1'b1;
    #1;
    chk("bad_rdy", 32'(b3.in_ready), 32'h0);
    tick();
    chk("bad_vld",  32'(b3.out_valid), 32'h0);
    chk("bad_data", 32'(b3.out_data),  32'h3C);

    // mid-operation reset on the stalled arbiter (ptr at 2)
    chk("mid_pre_vld", 32'(b1.out_valid), 32'h1);
    b1.in_valid = 4'b1110;
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(b1.in_ready), 32'h0);
    tick();
    chk("mid_vld",  32'(b1.out_valid), 32'h0);
    chk("mid_data", 32'(b1.out_data),  32'h0);
    chk("mid_chan", 32'(b1.out_chan),  32'h0);
    rst = 1'b0;
    #1;
    chk("mid_rel_rdy", 32'(b1.in_ready), 32'h2);
    tick();
    chk("mid_rel_chan", 32'(b1.out_chan),  32'h1);
    chk("mid_rel_data", 32'(b1.out_data),  32'h11);
    chk("mid_rel_vld",  32'(b1.out_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
